// File: rtl/serial_add_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_unit
// Description : Bit-serial adder. Operands are shifted LSB first through an
//               external 1-bit full adder, one bit per clock, and the result
//               is assembled in a right-shifting register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c;
  logic [c_CNT_W-1:0] r_cnt;
  // Only WIDTH-1 result bits are ever stored: the final bit arrives on the
  // last RUN edge and goes straight into sum together with the stored bits.
  logic [WIDTH-2:0]   r_res;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [WIDTH-1:0]   w_res_next;
  logic               w_last;

  assign w_res_next = {fa_sum, r_res};
  assign w_last     = (r_cnt == c_LAST);
  assign sum        = r_sum;
  assign cout       = r_cout;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: start only matters in IDLE, DONE always falls back
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_next = c_RUN;
      c_RUN:   if (w_last) w_state_next = c_DONE;
      c_DONE:  w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output decode: status flags and full-adder drive (zero outside RUN)
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_c = 1'b0;
    case (r_state)
      c_RUN: begin
        busy = 1'b1;
        fa_a = r_a[0];
        fa_b = r_b[0];
        fa_c = r_c;
      end
      c_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN edge,
  // publish sum/cout only on the final RUN edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        c_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= fa_carry;
          r_res <= w_res_next[WIDTH-1:1];
          r_cnt <= r_cnt + c_ONE;
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_unit
// Description : Self-checking bench for serial_add_unit (WIDTH=16) with an
//               external full-adder model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         fa_a, fa_b, fa_c;
  logic         fa_sum, fa_carry;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] prev_sum;
  bit mon_en = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_carry = 1'b0;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  // External full adder
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: scoreboard pop on done, full-adder drive and carry chain checks
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got sum=%0h cout=%0b with nothing expected", sum, cout);
        end else begin
          chk("result", {47'd0, cout, sum}, {47'd0, exp_q.pop_front()});
        end
      end
      if (!busy) begin
        chk("fa_idle", {61'd0, fa_a, fa_b, fa_c}, 64'd0);
      end else if (prev_busy) begin
        chk("fa_c_chain", {63'd0, fa_c}, {63'd0, prev_carry});
      end
      prev_busy  = busy;
      prev_carry = fa_carry;
    end
  end

  // One complete operation with cycle-accurate busy/done/sum-hold checks.
  // Operands are scrambled during RUN; optionally a colliding start is issued.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic [W:0] expv, input bit collide);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; cin = ic;
    exp_q.push_back(expv);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (collide && i == 3) begin
        start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
      end
      chk("busy_run", {63'd0, busy}, 64'd1);
      chk("done_run", {63'd0, done}, 64'd0);
      chk("sum_hold", {48'd0, sum}, {48'd0, prev_sum});
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_done", {63'd0, busy}, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("done_single", {63'd0, done}, 64'd0);
    prev_sum = expv[W-1:0];
  endtask

  initial begin
    int ndone;
    int last_cyc;
    int cyc;
    logic [W-1:0] hold;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    prev_sum = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", {48'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed vectors, expected {cout,sum} computed by hand
    run_op(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000}, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF}, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000}, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, {1'b0, 16'h0001}, 1'b0);
    run_op(16'hAAAA, 16'h5555, 1'b1, {1'b1, 16'h0000}, 1'b0);
    run_op(16'h00F0, 16'h0F0F, 1'b0, {1'b0, 16'h0FFF}, 1'b0);

    // Start collision during RUN, then a normal start afterwards
    run_op(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 1'b1);
    run_op(16'h0001, 16'h0001, 1'b0, {1'b0, 16'h0002}, 1'b0);

    // Reset abort on RUN cycle 5
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", {48'd0, sum}, 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    prev_sum = '0;
    repeat (W + 4) @(negedge clk);
    run_op(16'h0002, 16'h0003, 1'b0, {1'b0, 16'h0005}, 1'b0);

    // Back-to-back with start held high: one op per W+2 cycles
    @(negedge clk);
    start = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0;
    repeat (3) exp_q.push_back({1'b0, 16'h0303});
    hold = prev_sum;
    ndone = 0; last_cyc = 0; cyc = 0;
    while (cyc < 3 * (W + 2) + 20 && ndone < 3) begin
      @(negedge clk);
      cyc++;
      if (busy) chk("b2b_sum_hold", {48'd0, sum}, {48'd0, hold});
      if (done) begin
        ndone++;
        if (ndone > 1) chk("b2b_period", 64'(cyc - last_cyc), 64'(W + 2));
        last_cyc = cyc;
        hold = 16'h0303;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(ndone), 64'd3);

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
